// File: rtl/sd_cmd_issuer.sv
// Command-issue stage for the SD command serial host: builds the command and setting
// words, runs the REQ/ACK and status handshakes, captures the response and flags errors.
module sd_cmd_issuer #(
  parameter int unsigned TMO_W          = 16,
  parameter int unsigned LONG_RSP_SIZE  = 127,
  parameter int unsigned SHORT_RSP_SIZE = 40
) (
  input  logic             SD_CLK_IN,
  input  logic             RST_IN,
  input  logic             START,
  input  logic [5:0]       CMD_INDEX,
  input  logic [31:0]      CMD_ARG,
  input  logic [1:0]       RSP_TYPE,
  input  logic             CRC_CHK,
  input  logic             IDX_CHK,
  input  logic             BLK_RD,
  input  logic             BLK_WR,
  input  logic [1:0]       WORD_SEL,
  input  logic [2:0]       DLY_CYC,
  input  logic [TMO_W-1:0] TMO_LIMIT,
  output logic             BUSY,
  output logic             DONE,
  output logic [39:0]      RSP,
  output logic             ERR_CRC,
  output logic             ERR_IDX,
  output logic             ERR_TMO,
  output logic [39:0]      SER_CMD,
  output logic [15:0]      SER_SETTING,
  output logic             SER_REQ,
  input  logic             SER_ACK,
  input  logic             SER_STAT_REQ,
  output logic             SER_STAT_ACK,
  input  logic [15:0]      SER_STATUS,
  input  logic [39:0]      SER_RSP,
  output logic             SER_GO_IDLE
);

  localparam logic [6:0]       LONG_SZ  = 7'(LONG_RSP_SIZE);
  localparam logic [6:0]       SHORT_SZ = 7'(SHORT_RSP_SIZE);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_ABORT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [39:0]      rsp_q, rsp_d;
  logic             err_crc_q, err_crc_d;
  logic             err_idx_q, err_idx_d;
  logic             err_tmo_q, err_tmo_d;
  logic [39:0]      ser_cmd_q, ser_cmd_d;
  logic [15:0]      ser_setting_q, ser_setting_d;
  logic             ser_req_q, ser_req_d;
  logic             ser_stat_ack_q, ser_stat_ack_d;
  logic             ser_go_idle_q, ser_go_idle_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0] tmo_limit_q, tmo_limit_d;
  logic             final_seen_q, final_seen_d;
  logic             crc_ok_q, crc_ok_d;
  logic             stat_req_prev_q, stat_req_prev_d;
  logic             idx_chk_q, idx_chk_d;
  logic [1:0]       rsp_type_q, rsp_type_d;

  logic             tmo_hit_s;
  logic             stat_rise_s;
  logic             run_exit_s;
  logic [6:0]       rsp_size_s;

  // Next-state and next-output computation for the whole command sequence
  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    rsp_d           = rsp_q;
    err_crc_d       = err_crc_q;
    err_idx_d       = err_idx_q;
    err_tmo_d       = err_tmo_q;
    ser_cmd_d       = ser_cmd_q;
    ser_setting_d   = ser_setting_q;
    ser_req_d       = ser_req_q;
    ser_stat_ack_d  = 1'b0;
    ser_go_idle_d   = 1'b0;
    tmo_cnt_d       = tmo_cnt_q;
    tmo_limit_d     = tmo_limit_q;
    final_seen_d    = final_seen_q;
    crc_ok_d        = crc_ok_q;
    stat_req_prev_d = SER_STAT_REQ;
    idx_chk_d       = idx_chk_q;
    rsp_type_d      = rsp_type_q;

    tmo_hit_s   = (tmo_limit_q != TMO_ZERO) && ((tmo_cnt_q + TMO_ONE) == tmo_limit_q);
    stat_rise_s = SER_STAT_REQ & ~stat_req_prev_q;
    run_exit_s  = SER_ACK & final_seen_q & ~SER_STAT_REQ;

    case (RSP_TYPE)
      2'b00:   rsp_size_s = 7'd0;
      2'b10:   rsp_size_s = LONG_SZ;
      default: rsp_size_s = SHORT_SZ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d       = S_ISSUE;
          busy_d        = 1'b1;
          ser_req_d     = 1'b1;
          ser_cmd_d     = {2'b01, CMD_INDEX, CMD_ARG};
          ser_setting_d = {1'b0, WORD_SEL, BLK_RD, BLK_WR, DLY_CYC, CRC_CHK, rsp_size_s};
          err_crc_d     = 1'b0;
          err_idx_d     = 1'b0;
          err_tmo_d     = 1'b0;
          tmo_cnt_d     = TMO_ZERO;
          tmo_limit_d   = TMO_LIMIT;
          final_seen_d  = 1'b0;
          crc_ok_d      = 1'b0;
          idx_chk_d     = IDX_CHK;
          rsp_type_d    = RSP_TYPE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE, S_RUN: begin
        ser_stat_ack_d = SER_STAT_REQ;
        tmo_cnt_d      = tmo_cnt_q + TMO_ONE;
        // Status words are sampled once per request, on the rising edge of REQ
        if (stat_rise_s) begin
          if (SER_STATUS[6]) begin
            final_seen_d = 1'b1;
            crc_ok_d     = SER_STATUS[5];
          end else begin
            final_seen_d = final_seen_q;
          end
          if (SER_STATUS[3:0] == 4'b0110) begin
            rsp_d = SER_RSP;
          end else begin
            rsp_d = rsp_q;
          end
        end else begin
          rsp_d = rsp_q;
        end
        if ((state_q == S_RUN) && run_exit_s) begin
          state_d   = S_CHECK;
          ser_req_d = 1'b0;
        end else if (tmo_hit_s) begin
          state_d        = S_ABORT;
          ser_req_d      = 1'b0;
          ser_go_idle_d  = 1'b1;
          err_tmo_d      = 1'b1;
          ser_stat_ack_d = 1'b0;
        end else if ((state_q == S_ISSUE) && !SER_ACK) begin
          state_d   = S_RUN;
          ser_req_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
        err_crc_d = ser_setting_q[7] & (rsp_type_q != 2'b00) & ~crc_ok_q;
        err_idx_d = idx_chk_q & (rsp_type_q == 2'b01) & (rsp_q[37:32] != ser_cmd_q[37:32]);
        state_d   = S_DONE;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      S_ABORT: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        ser_req_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with synchronous active-low reset
  always_ff @(posedge SD_CLK_IN) begin
    if (!RST_IN) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rsp_q           <= 40'd0;
      err_crc_q       <= 1'b0;
      err_idx_q       <= 1'b0;
      err_tmo_q       <= 1'b0;
      ser_cmd_q       <= 40'd0;
      ser_setting_q   <= 16'd0;
      ser_req_q       <= 1'b0;
      ser_stat_ack_q  <= 1'b0;
      ser_go_idle_q   <= 1'b0;
      tmo_cnt_q       <= TMO_ZERO;
      tmo_limit_q     <= TMO_ZERO;
      final_seen_q    <= 1'b0;
      crc_ok_q        <= 1'b0;
      stat_req_prev_q <= 1'b0;
      idx_chk_q       <= 1'b0;
      rsp_type_q      <= 2'b00;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      rsp_q           <= rsp_d;
      err_crc_q       <= err_crc_d;
      err_idx_q       <= err_idx_d;
      err_tmo_q       <= err_tmo_d;
      ser_cmd_q       <= ser_cmd_d;
      ser_setting_q   <= ser_setting_d;
      ser_req_q       <= ser_req_d;
      ser_stat_ack_q  <= ser_stat_ack_d;
      ser_go_idle_q   <= ser_go_idle_d;
      tmo_cnt_q       <= tmo_cnt_d;
      tmo_limit_q     <= tmo_limit_d;
      final_seen_q    <= final_seen_d;
      crc_ok_q        <= crc_ok_d;
      stat_req_prev_q <= stat_req_prev_d;
      idx_chk_q       <= idx_chk_d;
      rsp_type_q      <= rsp_type_d;
    end
  end

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign RSP          = rsp_q;
  assign ERR_CRC      = err_crc_q;
  assign ERR_IDX      = err_idx_q;
  assign ERR_TMO      = err_tmo_q;
  assign SER_CMD      = ser_cmd_q;
  assign SER_SETTING  = ser_setting_q;
  assign SER_REQ      = ser_req_q;
  assign SER_STAT_ACK = ser_stat_ack_q;
  assign SER_GO_IDLE  = ser_go_idle_q;

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// Directed self-checking bench for sd_cmd_issuer; the serial host is played by the tasks.
module tb_sd_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [1:0]  rsp_type = 2'b00;
  logic        crc_chk = 1'b0;
  logic        idx_chk = 1'b0;
  logic        blk_rd = 1'b0;
  logic        blk_wr = 1'b0;
  logic [1:0]  word_sel = 2'b00;
  logic [2:0]  dly_cyc = 3'd0;
  logic [15:0] tmo_limit = 16'd0;
  logic        busy, done, err_crc, err_idx, err_tmo;
  logic [39:0] rsp, ser_cmd;
  logic [15:0] ser_setting;
  logic        ser_req, ser_stat_ack, ser_go_idle;
  logic        ser_ack = 1'b1;
  logic        ser_stat_req = 1'b0;
  logic [15:0] ser_status = 16'd0;
  logic [39:0] ser_rsp = 40'd0;

  int n_checks = 0;
  int n_fail = 0;

  sd_cmd_issuer dut (
    .SD_CLK_IN(clk), .RST_IN(rst_n), .START(start), .CMD_INDEX(cmd_index),
    .CMD_ARG(cmd_arg), .RSP_TYPE(rsp_type), .CRC_CHK(crc_chk), .IDX_CHK(idx_chk),
    .BLK_RD(blk_rd), .BLK_WR(blk_wr), .WORD_SEL(word_sel), .DLY_CYC(dly_cyc),
    .TMO_LIMIT(tmo_limit), .BUSY(busy), .DONE(done), .RSP(rsp), .ERR_CRC(err_crc),
    .ERR_IDX(err_idx), .ERR_TMO(err_tmo), .SER_CMD(ser_cmd), .SER_SETTING(ser_setting),
    .SER_REQ(ser_req), .SER_ACK(ser_ack), .SER_STAT_REQ(ser_stat_req),
    .SER_STAT_ACK(ser_stat_ack), .SER_STATUS(ser_status), .SER_RSP(ser_rsp),
    .SER_GO_IDLE(ser_go_idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic crc, input logic ic, input logic [2:0] dly,
                       input logic [15:0] tmo);
    cmd_index = idx; cmd_arg = arg; rsp_type = rt; crc_chk = crc; idx_chk = ic;
    dly_cyc = dly; tmo_limit = tmo; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Host accepts, returns one final status, goes idle; counts DONE pulses in a bounded window
  task automatic host_run(input logic [15:0] status, input logic [39:0] r, output int n_done);
    ser_ack = 1'b0;
    step();
    ser_stat_req = 1'b1; ser_status = status; ser_rsp = r;
    step();
    ser_stat_req = 1'b0;
    step();
    ser_ack = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) n_done++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_checks++; if ({busy, done, ser_req, ser_stat_ack, ser_go_idle} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, ser_req, ser_stat_ack, ser_go_idle}); end
    n_checks++; if ({err_crc, err_idx, err_tmo} !== 3'b000) begin
      n_fail++; $display("FAIL reset_err got %b want 000", {err_crc, err_idx, err_tmo}); end
    n_checks++; if ({rsp, ser_cmd, ser_setting} !== 96'd0) begin
      n_fail++; $display("FAIL reset_words got %h %h %h want 0", rsp, ser_cmd, ser_setting); end
  endtask

  task automatic test_short();
    int nd;
    issue(6'd17, 32'h0000_1000, 2'b01, 1'b1, 1'b0, 3'd0, 16'd0);
    n_checks++; if (ser_cmd !== 40'h51_0000_1000) begin
      n_fail++; $display("FAIL short_cmd got %h want 5100001000", ser_cmd); end
    n_checks++; if (ser_setting !== 16'h00A8) begin
      n_fail++; $display("FAIL short_setting got %h want 00a8", ser_setting); end
    n_checks++; if ({busy, ser_req} !== 2'b11) begin
      n_fail++; $display("FAIL short_issue got %b want 11", {busy, ser_req}); end
    ser_ack = 1'b0;
    step();
    n_checks++; if (ser_req !== 1'b0) begin
      n_fail++; $display("FAIL short_req_drop got %b want 0", ser_req); end
    ser_stat_req = 1'b1; ser_status = 16'h0066; ser_rsp = 40'h11_0000_0900;
    step();
    n_checks++; if (ser_stat_ack !== 1'b1) begin
      n_fail++; $display("FAIL short_stat_ack got %b want 1", ser_stat_ack); end
    ser_stat_req = 1'b0;
    step();
    n_checks++; if (ser_stat_ack !== 1'b0) begin
      n_fail++; $display("FAIL short_stat_ack_low got %b want 0", ser_stat_ack); end
    ser_ack = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) begin
        nd++;
        n_checks++; if (busy !== 1'b0) begin
          n_fail++; $display("FAIL short_busy_at_done got %b want 0", busy); end
      end
    end
    n_checks++; if (nd !== 1) begin
      n_fail++; $display("FAIL short_done_count got %0d want 1", nd); end
    n_checks++; if (rsp !== 40'h11_0000_0900) begin
      n_fail++; $display("FAIL short_rsp got %h want 1100000900", rsp); end
    n_checks++; if ({err_crc, err_idx, err_tmo} !== 3'b000) begin
      n_fail++; $display("FAIL short_err got %b want 000", {err_crc, err_idx, err_tmo}); end
  endtask

  task automatic test_no_rsp();
    int nd;
    issue(6'd0, 32'd0, 2'b00, 1'b0, 1'b0, 3'd3, 16'd0);
    n_checks++; if (ser_setting !== 16'h0300) begin
      n_fail++; $display("FAIL norsp_setting got %h want 0300", ser_setting); end
    n_checks++; if (ser_cmd !== 40'h40_0000_0000) begin
      n_fail++; $display("FAIL norsp_cmd got %h want 4000000000", ser_cmd); end
    host_run(16'h0044, 40'hAA_AAAA_AAAA, nd);
    n_checks++; if (nd !== 1) begin
      n_fail++; $display("FAIL norsp_done_count got %0d want 1", nd); end
    n_checks++; if (rsp !== 40'h11_0000_0900) begin
      n_fail++; $display("FAIL norsp_rsp_held got %h want 1100000900", rsp); end
  endtask

  task automatic test_crc_err();
    int nd;
    issue(6'd17, 32'h0000_1000, 2'b01, 1'b1, 1'b0, 3'd0, 16'd0);
    host_run(16'h0046, 40'h11_0000_0900, nd);
    n_checks++; if (nd !== 1) begin
      n_fail++; $display("FAIL crc_done_count got %0d want 1", nd); end
    n_checks++; if ({err_crc, err_idx, err_tmo} !== 3'b100) begin
      n_fail++; $display("FAIL crc_err got %b want 100", {err_crc, err_idx, err_tmo}); end
  endtask

  task automatic test_idx_err();
    int nd;
    issue(6'd17, 32'h0000_1000, 2'b01, 1'b1, 1'b1, 3'd0, 16'd0);
    n_checks++; if (err_crc !== 1'b0) begin
      n_fail++; $display("FAIL idx_err_cleared_on_start got %b want 0", err_crc); end
    host_run(16'h0066, 40'h12_0000_0900, nd);
    n_checks++; if (nd !== 1) begin
      n_fail++; $display("FAIL idx_done_count got %0d want 1", nd); end
    n_checks++; if ({err_crc, err_idx, err_tmo} !== 3'b010) begin
      n_fail++; $display("FAIL idx_err got %b want 010", {err_crc, err_idx, err_tmo}); end
  endtask

  task automatic test_timeout();
    int first_hi, n_hi, done_at, req_in_abort;
    first_hi = -1; n_hi = 0; done_at = -1; req_in_abort = 0;
    ser_ack = 1'b1;
    issue(6'd17, 32'h0000_1000, 2'b01, 1'b1, 1'b0, 3'd0, 16'd100);
    n_checks++; if (err_idx !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idx_cleared_on_start got %b want 0", err_idx); end
    for (int k = 1; k <= 150; k++) begin
      step();
      if (ser_go_idle === 1'b1) begin
        n_hi++;
        if (first_hi < 0) first_hi = k;
        if (ser_req !== 1'b0) req_in_abort++;
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    n_checks++; if (first_hi !== 100) begin
      n_fail++; $display("FAIL tmo_go_idle_cycle got %0d want 100", first_hi); end
    n_checks++; if (n_hi !== 1) begin
      n_fail++; $display("FAIL tmo_go_idle_width got %0d want 1", n_hi); end
    n_checks++; if (req_in_abort !== 0) begin
      n_fail++; $display("FAIL tmo_req_in_abort got %0d want 0", req_in_abort); end
    n_checks++; if (done_at !== 101) begin
      n_fail++; $display("FAIL tmo_done_cycle got %0d want 101", done_at); end
    n_checks++; if ({err_crc, err_idx, err_tmo, busy} !== 4'b0010) begin
      n_fail++; $display("FAIL tmo_flags got %b want 0010", {err_crc, err_idx, err_tmo, busy}); end
  endtask

  task automatic test_restart_reset();
    issue(6'd17, 32'h0000_1000, 2'b01, 1'b1, 1'b0, 3'd0, 16'd0);
    issue(6'd5, 32'h0000_FFFF, 2'b10, 1'b0, 1'b0, 3'd7, 16'd0);
    n_checks++; if (ser_cmd !== 40'h51_0000_1000) begin
      n_fail++; $display("FAIL restart_cmd_held got %h want 5100001000", ser_cmd); end
    n_checks++; if (ser_setting !== 16'h00A8) begin
      n_fail++; $display("FAIL restart_setting_held got %h want 00a8", ser_setting); end
    ser_ack = 1'b0;
    step();
    ser_stat_req = 1'b1; ser_status = 16'h0002;
    step();
    n_checks++; if ({busy, ser_stat_ack} !== 2'b11) begin
      n_fail++; $display("FAIL restart_run got %b want 11", {busy, ser_stat_ack}); end
    rst_n = 1'b0;
    step();
    n_checks++; if ({busy, ser_req, ser_stat_ack, ser_go_idle} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_cmd got %b want 0000", {busy, ser_req, ser_stat_ack, ser_go_idle}); end
    rst_n = 1'b1; ser_stat_req = 1'b0; ser_ack = 1'b1;
    step(); step();
    n_checks++; if ({busy, ser_req, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle_after got %b want 000", {busy, ser_req, done}); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_no_rsp();
    test_crc_err();
    test_idx_err();
    test_timeout();
    test_restart_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
